// File: rtl/prng_pkg.sv
// prng_pkg
// Shared definitions for the shared PRNG arbiter block.
//   - prng_state_t : controller state (LOAD, WARMUP, SERVE)
//   - LFSR_W       : LFSR width (only 32 is supported by the fixed polynomial)
//   - TAP_*        : feedback taps for x^32 + x^22 + x^2 + x + 1
//   - SEED_DEFAULT : seed used at reset and in place of an all-zero seed
//   - lfsr_next()  : one Fibonacci LFSR step
package prng_pkg;

    localparam int LFSR_W = 32;

    localparam int TAP_A = 31;
    localparam int TAP_B = 21;
    localparam int TAP_C = 1;
    localparam int TAP_D = 0;

    localparam logic [LFSR_W-1:0] SEED_DEFAULT = 32'hACE1_2468;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_SERVE  = 2'd2
    } prng_state_t;

    // Shift left and feed the XOR of the four taps into bit 0. A nonzero
    // state never maps to zero, so the zero-seed substitution is enough to
    // keep the generator out of the lockup state.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
    endfunction

endpackage

// File: rtl/prng_rr_arbiter.sv
// prng_rr_arbiter
// Combinational round-robin picker, reusable by any shared-resource
// scheduler that keeps its own pointer register.
// Parameters:
//   NUM_REQ  : number of requesters (2..8)
// Ports:
//   req      : in,  NUM_REQ  request vector (one decision per cycle)
//   en       : in,  1        allow a grant this cycle
//   ptr      : in,  PTR_W    current priority pointer (highest priority index)
//   gnt_next : out, NUM_REQ  one-hot winner, all zero when en=0 or no request
//   ptr_next : out, PTR_W    pointer value to load when a grant is taken
//   gnt_any  : out, 1        a winner exists
module prng_rr_arbiter
    import prng_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_next,
    output logic [PTR_W-1:0]   ptr_next,
    output logic               gnt_any
);

    int                 cand;
    logic [PTR_W-1:0]   idx;
    logic               found;

    // Walk the request vector starting at the pointer and wrapping modulo
    // NUM_REQ; the first asserted index wins and the pointer moves just past
    // it, so the winner gets lowest priority on the next decision.
    always_comb begin
        gnt_next = '0;
        ptr_next = ptr;
        found    = 1'b0;
        cand     = 0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            idx  = PTR_W'(cand);
            if (en && !found && req[idx]) begin
                gnt_next[idx] = 1'b1;
                ptr_next      = (cand == NUM_REQ - 1) ? '0 : PTR_W'(cand + 1);
                found         = 1'b1;
            end
        end
    end

    assign gnt_any = |gnt_next;

endmodule

// File: rtl/prng_arbiter.sv
// prng_arbiter
// One 32-bit Fibonacci LFSR shared round-robin between NUM_REQ consumers.
// After reset or a seed load the LFSR runs WARMUP_CYCLES discarded steps,
// then each cycle with a pending request hands the current word to exactly
// one requester and steps the LFSR.
// Parameters:
//   N             : LFSR width, must be 32
//   NUM_REQ       : requesters, 2..8
//   WARMUP_CYCLES : discarded steps after reset / seed load, 0..255
//   SEED_DEFAULT  : reset seed and substitute for an all-zero seed_in
// Ports:
//   clk       : in,  1        rising-edge clock
//   reset_n   : in,  1        synchronous active-low reset
//   seed_load : in,  1        pulse: reseed from seed_in
//   seed_in   : in,  N        seed, sampled with seed_load
//   req       : in,  NUM_REQ  level requests, held until served
//   gnt       : out, NUM_REQ  registered one-hot grant
//   rnd_valid : out, 1        rnd_data valid (|gnt)
//   rnd_data  : out, N        word for the granted requester
//   busy      : out, 1        registered, high while loading / warming up
module prng_arbiter #(
    parameter int            N             = 32,
    parameter int            NUM_REQ       = 4,
    parameter int            WARMUP_CYCLES = 16,
    parameter logic [N-1:0]  SEED_DEFAULT  = prng_pkg::SEED_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               seed_load,
    input  logic [N-1:0]       seed_in,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               rnd_valid,
    output logic [N-1:0]       rnd_data,
    output logic               busy
);

    import prng_pkg::*;

    localparam int          PTR_W       = $clog2(NUM_REQ);
    localparam logic [7:0]  WARMUP_INIT = 8'(WARMUP_CYCLES);
    localparam prng_state_t POST_LOAD   = (WARMUP_CYCLES == 0) ? ST_SERVE : ST_WARMUP;

    prng_state_t          state;
    prng_state_t          state_nxt;
    logic [N-1:0]         lfsr;
    logic [N-1:0]         lfsr_nxt;
    logic [N-1:0]         seed_q;
    logic [7:0]           warm_cnt;
    logic [7:0]           warm_cnt_nxt;
    logic [NUM_REQ-1:0]   req_q;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     ptr_next;
    logic [NUM_REQ-1:0]   gnt_next;
    logic                 gnt_any;
    logic                 arb_en;

    // A decision is only taken in SERVE; a seed load in the same cycle
    // cancels it, so no grant is issued and the LFSR does not step.
    assign arb_en = (state == ST_SERVE) && !seed_load;

    prng_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req      (req_q),
        .en       (arb_en),
        .ptr      (ptr),
        .gnt_next (gnt_next),
        .ptr_next (ptr_next),
        .gnt_any  (gnt_any)
    );

    // Next-state logic. seed_load takes priority from any state, which also
    // restarts LOAD when it arrives during LOAD or WARMUP. LOAD copies the
    // captured seed into the LFSR; WARMUP steps once per cycle and hands over
    // to SERVE on its last step; SERVE steps only when a word is handed out.
    always_comb begin
        state_nxt    = state;
        lfsr_nxt     = lfsr;
        warm_cnt_nxt = warm_cnt;
        if (seed_load) begin
            state_nxt = ST_LOAD;
        end else begin
            case (state)
                ST_LOAD: begin
                    lfsr_nxt     = seed_q;
                    warm_cnt_nxt = WARMUP_INIT;
                    state_nxt    = POST_LOAD;
                end
                ST_WARMUP: begin
                    lfsr_nxt     = lfsr_next(lfsr);
                    warm_cnt_nxt = warm_cnt - 8'd1;
                    if (warm_cnt <= 8'd1) begin
                        state_nxt = ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (gnt_any) begin
                        lfsr_nxt = lfsr_next(lfsr);
                    end
                end
                default: begin
                    state_nxt = ST_LOAD;
                end
            endcase
        end
    end

    // State, LFSR and warm-up counter registers. Reset behaves like a load
    // of SEED_DEFAULT that has already completed its LOAD cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= POST_LOAD;
            lfsr     <= SEED_DEFAULT;
            warm_cnt <= WARMUP_INIT;
        end else begin
            state    <= state_nxt;
            lfsr     <= lfsr_nxt;
            warm_cnt <= warm_cnt_nxt;
        end
    end

    // Seed capture. The zero check happens here so that the LFSR can never
    // be loaded with the all-zero lockup value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seed_q <= SEED_DEFAULT;
        end else if (seed_load) begin
            seed_q <= (seed_in == '0) ? SEED_DEFAULT : seed_in;
        end
    end

    // Requests are registered first, so the grant for a request sampled at
    // one edge appears after the following edge. The pointer only moves on
    // an actual grant and survives seed loads.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_q <= '0;
            ptr   <= '0;
        end else begin
            req_q <= req;
            if (gnt_any) begin
                ptr <= ptr_next;
            end
        end
    end

    // Output registers. rnd_data keeps the last delivered word when idle;
    // busy looks ahead at the next state so it is low from the first SERVE
    // cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gnt      <= '0;
            rnd_data <= '0;
            busy     <= 1'b1;
        end else begin
            gnt  <= gnt_next;
            busy <= (state_nxt != ST_SERVE);
            if (gnt_any) begin
                rnd_data <= lfsr;
            end
        end
    end

    assign rnd_valid = |gnt;

endmodule

// File: doc/prng_arbiter.md
# prng_arbiter

Shares one 32-bit Fibonacci LFSR pseudo-random source between `NUM_REQ` requesters. The block handles seed loading with zero-seed lockup protection and a warm-up run of discarded steps. It then serves random words round-robin, one word per cycle, one requester per cycle. It sits between the PRNG core and the consumers (test-pattern generators, dither units) that previously each needed a private generator.

## Interface
- `N`, 32, LFSR width; polynomial fixed at x^32+x^22+x^2+x+1 (taps 31, 21, 1, 0), so only N=32 is legal.
- `NUM_REQ`, 4, number of requesters, 2..8.
- `WARMUP_CYCLES`, 16, LFSR steps discarded after every seed load or reset, 0..255.
- `SEED_DEFAULT`, 32'hACE1_2468, seed used at reset and substituted for an all-zero `seed_in`.

- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: reset, synchronous and active-low.
- `seed_load` input 1: one-cycle pulse; reseed from `seed_in`.
- `seed_in` input N: seed value, sampled when `seed_load`=1.
- `req` input NUM_REQ: per-requester level request, held until served.
- `gnt` output NUM_REQ: one-hot grant, registered.
- `rnd_valid` output 1: `rnd_data` valid this cycle; equals |`gnt`.
- `rnd_data` output N: random word for the granted requester.
- `busy` output 1: high in LOAD/WARMUP; no grants are issued.

## Operation
- LFSR step: `s <= {s[30:0], s[31]^s[21]^s[1]^s[0]}`.
- States:
  - LOAD (1 cycle): `s <=` seed (or `SEED_DEFAULT` if the seed is zero); warm-up counter `<= WARMUP_CYCLES`.
  - WARMUP: one step per cycle; counter decrements; leave when the counter = 0. With `WARMUP_CYCLES`=0, go from LOAD directly to SERVE.
  - SERVE: arbitrate and grant.
- SERVE arbitration: round-robin with pointer `p` (reset 0). Search `req` from index `p` upward, modulo `NUM_REQ`. The first asserted index `i` wins.
  - Next cycle: `gnt[i]`=1, `rnd_data`=current `s`, `rnd_valid`=1. `s` steps once. `p <= (i+1) mod NUM_REQ`.
  - No `req` bits set: `gnt`=0, `rnd_valid`=0, `rnd_data` holds its last value, `s` does not step, `p` unchanged.
- A requester holding `req` receives one word per grant. Its next grant waits until the other active requesters have each been served once, so the maximum wait is `NUM_REQ`-1 grants.
- Every word is delivered to exactly one requester; no word is ever duplicated.

## Timing
- `req` sampled at edge t gives `gnt`/`rnd_data` valid after edge t+1 (1-cycle latency). Back-to-back grants occur every cycle while any `req` is high.
- Reset (`reset_n`=0 at an edge): `gnt`=0, `rnd_valid`=0, `rnd_data`=0, `busy`=1, `p`=0, `s`=`SEED_DEFAULT`, state=WARMUP with counter=`WARMUP_CYCLES` (SERVE if 0). Reset overrides everything, including mid-warm-up and mid-grant.
- `seed_load` in any state goes to LOAD on the next edge. An in-flight decision that cycle is dropped: no grant is issued and `s` is not stepped. `p` is preserved.
- `seed_load` while in LOAD or WARMUP restarts LOAD with the new seed.
- `busy` is registered. It is high during the LOAD and WARMUP cycles and low from the first SERVE cycle.
- A requester dropping `req` in the same cycle it is sampled is still granted; `req` is a level and the sampled value rules.
- Zero seed: `seed_in`=0 loads `SEED_DEFAULT`. The LFSR never reaches the all-zero state.

## Structure
- Shared package `prng_pkg`:
  - state enum (LOAD, WARMUP, SERVE);
  - `LFSR_W`=32;
  - tap constants 31/21/1/0;
  - function `lfsr_next(s)`;
  - `SEED_DEFAULT`.
- One sub-module `prng_rr_arbiter` (params `NUM_REQ`): inputs `req`, `en`; outputs one-hot `gnt_next` and pointer update. This sub-module is reusable by other shared-resource schedulers.
- The LFSR register, FSM and output registers live in `prng_arbiter` and use `lfsr_next`.

## Test plan
- Reset with `WARMUP_CYCLES`=0, then pulse `seed_load` with `seed_in`=32'h1 and hold `req`=4'b0001 → `busy` high 1 cycle; `gnt`=0001 with `rnd_data` 32'h1, 32'h3, 32'h6, 32'hD on consecutive cycles.
- Same setup with `WARMUP_CYCLES`=4 → `busy` high 5 cycles; first `rnd_data` = 32'h1B.
- `req`=4'b1111 held → `gnt` sequence 0001, 0010, 0100, 1000, 0001, ...; successive words follow the LFSR sequence with no repeats.
- `req`=4'b1010 with `p`=0 → `gnt` 0010, 1000, 0010, ...; then drop to `req`=0 → `rnd_valid`=0, `rnd_data` held, LFSR frozen. Resume → next word continues the sequence without a gap.
- `seed_in`=0 with `seed_load` → the behaviour matches loading 32'hACE1_2468 exactly.
- `seed_load` asserted in the same cycle as a pending `req`, and `reset_n` low during WARMUP → no grant that cycle; outputs return to reset values; the sequence restarts from the respective seed.
